vid_timing_gen: RTL and testbench

- Parametrised video timing generator for the HDMI back-end. It is the successor to the fixed-mode timing in the HDMI path.
- Produces hsync/vsync/blank/de, pixel coordinates and frame/line strobes.
- Issues a pixel-fetch request PREFETCH cycles ahead of de, so the rgb2hdmi FIFO read path can be pipelined.
- Adds enable, mid-stream resync to CSI frame start, and a frame counter.

---
 rtl/vid_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vid_timing_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Parametrised video timing generator: free-running h/v counters, a pixel-fetch
// request, and display-side syncs/coordinates delayed PREFETCH cycles behind it.
`timescale 1ns/1ps

module vid_timing_gen #(
   parameter int   CNT_W    = 12,
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 110,
   parameter int   H_SYNC   = 40,
   parameter int   H_BP     = 220,
   parameter int   V_ACTIVE = 720,
   parameter int   V_FP     = 5,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 20,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   PREFETCH = 1,
   parameter int   FCNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              resync,
   output logic              pix_req,
   output logic              de,
   output logic              blank,
   output logic              hsync,
   output logic              vsync,
   output logic [CNT_W-1:0]  x,
   output logic [CNT_W-1:0]  y,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   if (H_TOTAL > (1 << CNT_W)) begin : g_h_total_chk
      $error("vid_timing_gen: H_TOTAL does not fit in CNT_W bits");
   end
   if (V_TOTAL > (1 << CNT_W)) begin : g_v_total_chk
      $error("vid_timing_gen: V_TOTAL does not fit in CNT_W bits");
   end
   if (PREFETCH < 1 || PREFETCH > 8) begin : g_prefetch_chk
      $error("vid_timing_gen: PREFETCH must be within 1..8");
   end

   // Compares are done one bit wider so totals equal to 2^CNT_W still work.
   localparam logic [CNT_W:0]   H_ACT_W  = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT_W  = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]   HS_LO_W  = (CNT_W+1)'(HS_START);
   localparam logic [CNT_W:0]   HS_HI_W  = (CNT_W+1)'(HS_END);
   localparam logic [CNT_W:0]   VS_LO_W  = (CNT_W+1)'(VS_START);
   localparam logic [CNT_W:0]   VS_HI_W  = (CNT_W+1)'(VS_END);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

   typedef struct packed {
      logic             active;
      logic             hs;
      logic             vs;
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] v;
   } tuple_t;

   localparam tuple_t IDLE = '0;

   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   logic [CNT_W:0]   hc_w;
   logic [CNT_W:0]   vc_w;
   tuple_t           tup_next;
   tuple_t           pipe [PREFETCH+1];
   tuple_t           disp;

   assign hc_w = {1'b0, hc};
   assign vc_w = {1'b0, vc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc <= '0;
         vc <= '0;
      end else if (!en || resync) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
      end else begin
         hc <= hc + CNT_W'(1);
      end
   end

   // Gating by en makes a disabled generator emit the idle tuple.
   always_comb begin
      tup_next = IDLE;
      if (en) begin
         tup_next.active = (hc_w < H_ACT_W) && (vc_w < V_ACT_W);
         tup_next.hs     = (hc_w >= HS_LO_W) && (hc_w < HS_HI_W);
         tup_next.vs     = (vc_w >= VS_LO_W) && (vc_w < VS_HI_W);
         tup_next.h      = hc;
         tup_next.v      = vc;
      end
   end

   // Stage 0 is the request side; stage PREFETCH drives the display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= PREFETCH; i++) begin
            pipe[i] <= IDLE;
         end
      end else begin
         pipe[0] <= tup_next;
         for (int i = 1; i <= PREFETCH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign disp        = pipe[PREFETCH];
   assign pix_req     = pipe[0].active;
   assign de          = disp.active;
   assign blank       = ~disp.active;
   assign hsync       = disp.hs ? HS_POL : ~HS_POL;
   assign vsync       = disp.vs ? VS_POL : ~VS_POL;
   assign x           = disp.h;
   assign y           = disp.v;
   assign line_start  = disp.active && (disp.h == '0);
   assign frame_start = line_start && (disp.v == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: randomized en/resync against a linear-pixel-index
// reference model; two instances cover both sync polarities.
`timescale 1ns/1ps

module tb_vid_timing_gen;

   localparam int HA = 4, HFP = 1, HSW = 2, HBP = 1;
   localparam int VA = 3, VFP = 1, VSW = 1, VBP = 1;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int P  = 2;
   localparam int CW = 12;
   localparam int FW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic en = 1'b0;
   logic resync = 1'b0;

   always #5 clk = ~clk;

   logic          pix_req, de, blank, hsync, vsync, line_start, frame_start;
   logic [CW-1:0] x, y;
   logic [FW-1:0] frame_cnt;
   logic          pix_req_n, de_n, blank_n, hsync_n, vsync_n, line_start_n, frame_start_n;
   logic [CW-1:0] x_n, y_n;
   logic [FW-1:0] frame_cnt_n;

   vid_timing_gen #(
      .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(P), .FCNT_W(FW)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .resync(resync),
      .pix_req(pix_req), .de(de), .blank(blank), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
      .frame_cnt(frame_cnt)
   );

   vid_timing_gen #(
      .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(P), .FCNT_W(FW)
   ) dut_n (
      .clk(clk), .reset(reset), .en(en), .resync(resync),
      .pix_req(pix_req_n), .de(de_n), .blank(blank_n), .hsync(hsync_n), .vsync(vsync_n),
      .x(x_n), .y(y_n), .line_start(line_start_n), .frame_start(frame_start_n),
      .frame_cnt(frame_cnt_n)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          req;
      logic          de;
      logic          hs;
      logic          vs;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          fs;
      logic [FW-1:0] fc;
   } exp_t;

   typedef struct {
      bit act;
      bit hs;
      bit vs;
      int h;
      int v;
   } tup_m;

   exp_t exp_q[$];
   tup_m hist[$];
   int   pos;       // linear pixel index within the frame: v*HT + h
   int   fc_m;
   int   checks = 0;
   int   errors = 0;
   int   fs_seen = 0;
   bit   last_de;

   task automatic model_reset();
      tup_m idle;
      idle = '{act: 1'b0, hs: 1'b0, vs: 1'b0, h: 0, v: 0};
      hist.delete();
      for (int i = 0; i < P; i++) hist.push_back(idle);
      pos  = 0;
      fc_m = 0;
   endtask

   task automatic model_cycle(input bit e, input bit r);
      tup_m t, d;
      exp_t ex;
      int   h, v;
      h = pos % HT;
      v = pos / HT;
      t.act = e && (h < HA) && (v < VA);
      t.hs  = e && (h >= HA + HFP) && (h < HA + HFP + HSW);
      t.vs  = e && (v >= VA + VFP) && (v < VA + VFP + VSW);
      t.h   = e ? h : 0;
      t.v   = e ? v : 0;
      pos = (!e || r) ? 0 : (pos + 1) % (HT * VT);
      hist.push_back(t);
      d = hist.pop_front();
      ex.req = t.act;
      ex.de  = d.act;
      ex.hs  = d.hs;
      ex.vs  = d.vs;
      ex.x   = CW'(d.h);
      ex.y   = CW'(d.v);
      ex.fs  = d.act && d.h == 0 && d.v == 0;
      ex.fc  = FW'(fc_m);
      if (ex.fs) fc_m = (fc_m + 1) % (1 << FW);
      last_de = ex.de;
      exp_q.push_back(ex);
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_p"}, 64'({pix_req, de, blank, line_start, frame_start, hsync, vsync, x, y, frame_cnt}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0), CW'(0), FW'(0)}));
      chk({name, "_n"}, 64'({pix_req_n, de_n, blank_n, line_start_n, frame_start_n, hsync_n, vsync_n, x_n, y_n, frame_cnt_n}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CW'(0), CW'(0), FW'(0)}));
   endtask

   // Monitor: one expected entry per clock edge issued by the driver.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (frame_start === 1'b1) fs_seen++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req", 64'(pix_req), 64'(e.req));
            chk("disp", 64'({de, blank, x, y, line_start, frame_start}),
                64'({e.de, ~e.de, e.x, e.y, e.de && e.x == 0, e.fs}));
            chk("sync", 64'({hsync, vsync}), 64'({e.hs, e.vs}));
            chk("fcnt", 64'(frame_cnt), 64'(e.fc));
            chk("inst_n", 64'({pix_req_n, de_n, blank_n, hsync_n, vsync_n, x_n, y_n, frame_start_n, frame_cnt_n}),
                64'({e.req, e.de, ~e.de, ~e.hs, ~e.vs, e.x, e.y, e.fs, e.fc}));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit e, input bit r);
      @(negedge clk);
      en     = e;
      resync = r;
      model_cycle(e, r);
   endtask

   task automatic async_reset_mid_active();
      int n = 0;
      while (!last_de && n < 100) begin
         step(1'b1, 1'b0);
         n++;
      end
      chk("reach_active", 64'(last_de), 64'(1));
      @(posedge clk);
      #3;
      reset  = 1'b1;
      en     = 1'b0;
      resync = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, n;
      model_reset();
      last_de = 1'b0;
      #1 reset = 1'b1;
      #1 chk_reset_vals("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Free run from origin for five frames.
      base = fs_seen;
      for (int i = 0; i < 5 * HT * VT; i++) step(1'b1, 1'b0);
      @(posedge clk);
      #2;
      chk("fs_count_5frames", 64'(fs_seen - base), 64'(5));
      chk("fcnt_after_5", 64'(frame_cnt), 64'(1));

      // Resync pulse at hc=2, vc=1.
      n = 0;
      while (pos != HT + 2 && n < 100) begin
         step(1'b1, 1'b0);
         n++;
      end
      step(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

      // en dropped mid-line, then re-enabled.
      n = 0;
      while (!(pos % HT == 1 && pos / HT < VA) && n < 100) begin
         step(1'b1, 1'b0);
         n++;
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

      // resync and en=0 together.
      step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

      async_reset_mid_active();
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

      // Randomized en / resync.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0);
         if ($urandom_range(0, 299) == 0) async_reset_mid_active();
      end

      for (int i = 0; i < P + 2; i++) step(1'b0, 1'b0);
      @(posedge clk);
      #3;
      chk("drain", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
